dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port 16x8 data memory. Port 0 is the CPU load/store unit; port 1 is the DMA/debug loader. The block grants one requester per cycle and drives the memory enable, write-enable, address and data lines. It registers read data into a one-cycle response, and supports a bounded lock so one port can perform atomic read-modify-write sequences.

---
 rtl/dmem_arb_pkg.sv | 20 ++
 rtl/dmem_arb_pick.sv | 41 ++++
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Sized to match the 16x8 single-port data memory.
package dmem_arb_pkg;

   localparam int unsigned NUM_PORTS   = 2;
   localparam int unsigned DMEM_ADDR_W = 4;
   localparam int unsigned DMEM_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   // One-hot grant vector for a port index.
   function automatic logic [NUM_PORTS-1:0] port_onehot(input logic p);
      return p ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational two-way pick for the data-memory arbiter.
// Build option: DMEM_ARB_RR_EN selects round-robin conflict resolution
// (port != last wins); otherwise port 0 wins conflicts. A pending forced
// release always hands a conflict to the port that did not own the lock.
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req,
   input  logic [NUM_PORTS-1:0] eligible,
   input  logic                 last,
   input  logic                 force_other,
   output logic [NUM_PORTS-1:0] winner
);

   logic [NUM_PORTS-1:0] cand;
   logic                 mode_pref;
   logic                 pref;

   assign cand = req & eligible;

`ifdef DMEM_ARB_RR_EN
   assign mode_pref = ~last;
`else
   assign mode_pref = 1'b0;
`endif

   // After a forced release, last still names the previous owner.
   assign pref = force_other ? ~last : mode_pref;

   // Resolve to a single one-hot winner among eligible requesters.
   always_comb begin
      winner = '0;
      case (cand)
         2'b01:   winner = 2'b01;
         2'b10:   winner = 2'b10;
         2'b11:   winner = port_onehot(pref);
         default: winner = '0;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Port 0 = CPU load/store, port 1 = DMA/debug loader. Supports a bounded
// per-port lock for atomic read-modify-write sequences.
// Build option: DMEM_ARB_RR_EN (round-robin IDLE arbitration, in dmem_arb_pick).
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W   = DMEM_ADDR_W,
   parameter int unsigned DATA_W   = DMEM_DATA_W,
   parameter int unsigned MAX_LOCK = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [1:0]            req,
   input  logic [1:0]            we,
   input  logic [1:0]            lock,
   input  logic [2*ADDR_W-1:0]   addr,
   input  logic [2*DATA_W-1:0]   wdata,
   output logic [1:0]            gnt,
   output logic [1:0]            rvalid,
   output logic [DATA_W-1:0]     rdata,
   output logic                  mem_E,
   output logic                  mem_WE,
   output logic [ADDR_W-1:0]     mem_Addr,
   output logic [DATA_W-1:0]     mem_Data_in,
   input  logic [DATA_W-1:0]     mem_Data_out
);

   arb_state_t           state;
   arb_state_t           state_nxt;
   logic [7:0]           lock_cnt;
   logic [7:0]           lock_cnt_nxt;
   logic                 last;
   logic                 force_other;
   logic                 force_nxt;
   logic [1:0]           eligible;
   logic [1:0]           pick_gnt;
   logic                 sel;
   logic                 own;
   logic                 lock_own;
   logic                 lock_hit;
   logic [1:0]           rd_gnt;
   logic [ADDR_W-1:0]    addr_sel;
   logic [DATA_W-1:0]    wdata_sel;
   logic                 we_sel;

   // Only the owner may be granted while a lock is held.
   always_comb begin
      eligible = '0;
      case (state)
         IDLE:    eligible = 2'b11;
         OWN0:    eligible = 2'b01;
         OWN1:    eligible = 2'b10;
         default: eligible = '0;
      endcase
   end

   dmem_arb_pick u_pick (
      .req         (req),
      .eligible    (eligible),
      .last        (last),
      .force_other (force_other),
      .winner      (pick_gnt)
   );

   assign gnt = rst_n ? pick_gnt : '0;
   assign sel = gnt[1];

   assign addr_sel  = sel ? addr[2*ADDR_W-1:ADDR_W]   : addr[ADDR_W-1:0];
   assign wdata_sel = sel ? wdata[2*DATA_W-1:DATA_W]  : wdata[DATA_W-1:0];
   assign we_sel    = sel ? we[1] : we[0];

   assign mem_E       = |gnt;
   assign mem_WE      = mem_E & we_sel;
   assign mem_Addr    = mem_E ? addr_sel  : '0;
   assign mem_Data_in = mem_E ? wdata_sel : '0;

   assign rd_gnt = gnt & ~we;

   assign own      = (state == OWN1);
   assign lock_own = own ? lock[1] : lock[0];
   // The cycle that brings the count to MAX_LOCK is the last one owned,
   // so IDLE entry plus MAX_LOCK-1 owned cycles make MAX_LOCK in total.
   assign lock_hit = ({1'b0, lock_cnt} + 9'd1) >= 9'(MAX_LOCK);

   // Next-state, lock counter and forced-release flag.
   always_comb begin
      state_nxt    = state;
      lock_cnt_nxt = lock_cnt;
      force_nxt    = 1'b0;
      case (state)
         IDLE: begin
            if (mem_E && (sel ? lock[1] : lock[0])) begin
               state_nxt    = sel ? OWN1 : OWN0;
               lock_cnt_nxt = 8'd1;
            end
         end
         OWN0, OWN1: begin
            lock_cnt_nxt = lock_cnt + 8'd1;
            if (!lock_own || lock_hit) begin
               state_nxt    = IDLE;
               lock_cnt_nxt = '0;
               force_nxt    = lock_own;
            end
         end
         default: begin
            state_nxt    = IDLE;
            lock_cnt_nxt = '0;
         end
      endcase
   end

   // FSM state, lock counter and last-winner tracking.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         lock_cnt    <= '0;
         last        <= 1'b1;
         force_other <= 1'b0;
      end else begin
         state       <= state_nxt;
         lock_cnt    <= lock_cnt_nxt;
         force_other <= force_nxt;
         if (mem_E) begin
            last <= sel;
         end
      end
   end

   // One-cycle read response; rdata holds between responses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rvalid <= '0;
         rdata  <= '0;
      end else begin
         rvalid <= rd_gnt;
         if (|rd_gnt) begin
            rdata <= mem_Data_out;
         end
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural 16x8 memory and
// a read-response scoreboard.
module tb_dmem_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [1:0]  lock;
   logic [7:0]  addr;
   logic [15:0] wdata;
   logic [1:0]  gnt;
   logic [1:0]  rvalid;
   logic [7:0]  rdata;
   logic        mem_E;
   logic        mem_WE;
   logic [3:0]  mem_Addr;
   logic [7:0]  mem_Data_in;
   logic [7:0]  mem_Data_out;

   int checks = 0;
   int errors = 0;
   int unsigned cyc = 0;

   typedef struct {
      int unsigned due;
      logic [1:0]  vld;
      logic [7:0]  data;
   } rsp_t;
   rsp_t sbq[$];

   logic [7:0] mem [16];
   logic [7:0] ref_mem [16];

   dmem_arbiter #(.ADDR_W(4), .DATA_W(8), .MAX_LOCK(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .we           (we),
      .lock         (lock),
      .addr         (addr),
      .wdata        (wdata),
      .gnt          (gnt),
      .rvalid       (rvalid),
      .rdata        (rdata),
      .mem_E        (mem_E),
      .mem_WE       (mem_WE),
      .mem_Addr     (mem_Addr),
      .mem_Data_in  (mem_Data_in),
      .mem_Data_out (mem_Data_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   assign mem_Data_out = mem[mem_Addr];
   always @(posedge clk) begin
      if (mem_E && mem_WE) mem[mem_Addr] <= mem_Data_in;
   end

   // Response monitor: pop the expectation due this cycle and compare.
   rsp_t       mon_e;
   logic [1:0] mon_v;
   logic [7:0] mon_d;
   always @(negedge clk) begin
      if (rst_n) begin
         mon_v = '0;
         mon_d = '0;
         if (sbq.size() > 0 && sbq[0].due == cyc) begin
            mon_e = sbq.pop_front();
            mon_v = mon_e.vld;
            mon_d = mon_e.data;
         end
         checks++;
         if (rvalid !== mon_v) begin
            errors++;
            $display("FAIL rvalid cyc=%0d got=%b exp=%b", cyc, rvalid, mon_v);
         end
         if (mon_v != 2'b00) begin
            checks++;
            if (rdata !== mon_d) begin
               errors++;
               $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, rdata, mon_d);
            end
         end
      end
   end

   task automatic set_port(input int p, input logic r, input logic w, input logic l,
                           input logic [3:0] a, input logic [7:0] d);
      req[p]          = r;
      we[p]           = w;
      lock[p]         = l;
      addr[p*4 +: 4]  = a;
      wdata[p*8 +: 8] = d;
   endtask

   task automatic idle_ports();
      req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
   endtask

   task automatic push_rsp(input logic [1:0] v, input logic [7:0] d);
      rsp_t e;
      e.due  = cyc + 1;
      e.vld  = v;
      e.data = d;
      sbq.push_back(e);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      set_port(0, 1'b1, 1'b0, 1'b0, 4'd0, 8'h00);
      set_port(1, 1'b1, 1'b0, 1'b0, 4'd1, 8'h00);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (gnt !== 2'b00 || mem_E !== 1'b0 || mem_WE !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs gnt=%b mem_E=%b mem_WE=%b exp 00/0/0", gnt, mem_E, mem_WE);
         end
         checks++;
         if (rvalid !== 2'b00 || mem_Addr !== 4'd0 || mem_Data_in !== 8'd0) begin
            errors++;
            $display("FAIL reset_regs rvalid=%b addr=%h din=%h exp 0", rvalid, mem_Addr, mem_Data_in);
         end
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (gnt !== 2'b01) begin
         errors++;
         $display("FAIL reset_release_gnt got=%b exp=01", gnt);
      end
      push_rsp(2'b01, ref_mem[0]);
      @(posedge clk); #1;
      idle_ports();
   endtask

   task automatic test_write_read();
      logic [3:0] wa [2];
      logic [7:0] wd [2];
      wa[0] = 4'd3; wd[0] = 8'hA5;
      wa[1] = 4'd9; wd[1] = 8'h3C;
      for (int i = 0; i < 2; i++) begin
         set_port(1, 1'b1, 1'b1, 1'b0, wa[i], wd[i]);
         @(negedge clk);
         checks++;
         if (gnt !== 2'b10 || mem_WE !== 1'b1 || mem_Addr !== wa[i] || mem_Data_in !== wd[i]) begin
            errors++;
            $display("FAIL p1_write gnt=%b we=%b addr=%h din=%h exp 10/1/%h/%h",
                     gnt, mem_WE, mem_Addr, mem_Data_in, wa[i], wd[i]);
         end
         ref_mem[wa[i]] = wd[i];
         @(posedge clk); #1;
      end
      set_port(1, 1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
      @(negedge clk);
      checks++;
      if (gnt !== 2'b10 || mem_E !== 1'b1 || mem_WE !== 1'b0 || mem_Addr !== 4'd3) begin
         errors++;
         $display("FAIL p1_read gnt=%b E=%b WE=%b addr=%h exp 10/1/0/3", gnt, mem_E, mem_WE, mem_Addr);
      end
      push_rsp(2'b10, ref_mem[3]);
      @(posedge clk); #1;
      idle_ports();
      @(negedge clk);
      checks++;
      if (gnt !== 2'b00 || mem_E !== 1'b0 || mem_Addr !== 4'd0) begin
         errors++;
         $display("FAIL idle_outputs gnt=%b E=%b addr=%h exp 00/0/0", gnt, mem_E, mem_Addr);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [1:0] exp_g;
      set_port(0, 1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
      set_port(1, 1'b1, 1'b0, 1'b0, 4'd9, 8'h00);
      for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
`else
         exp_g = 2'b01;
`endif
         @(negedge clk);
         checks++;
         if (gnt !== exp_g) begin
            errors++;
            $display("FAIL b2b_gnt[%0d] got=%b exp=%b", i, gnt, exp_g);
         end
         push_rsp(exp_g, exp_g[1] ? ref_mem[9] : ref_mem[3]);
         @(posedge clk); #1;
      end
      idle_ports();
   endtask

   task automatic test_lock();
      set_port(1, 1'b1, 1'b0, 1'b0, 4'd9, 8'h00);
      for (int i = 0; i < 3; i++) begin
         set_port(0, 1'b1, (i == 1), 1'b1, 4'd5, 8'h5A);
         @(negedge clk);
         checks++;
         if (gnt !== 2'b01 || mem_WE !== (i == 1)) begin
            errors++;
            $display("FAIL lock_hold[%0d] gnt=%b we=%b exp 01/%0d", i, gnt, mem_WE, (i == 1));
         end
         if (i == 1) ref_mem[5] = 8'h5A;
         else        push_rsp(2'b01, ref_mem[5]);
         @(posedge clk); #1;
      end
      set_port(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      @(negedge clk);
      checks++;
      if (gnt !== 2'b00) begin
         errors++;
         $display("FAIL lock_drop_gnt got=%b exp=00", gnt);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (gnt !== 2'b10) begin
         errors++;
         $display("FAIL lock_after_gnt got=%b exp=10", gnt);
      end
      push_rsp(2'b10, ref_mem[9]);
      @(posedge clk); #1;
      idle_ports();
   endtask

   task automatic test_forced_release();
      logic [1:0] exp_g;
      set_port(0, 1'b1, 1'b0, 1'b1, 4'd5, 8'h00);
      set_port(1, 1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
      for (int i = 0; i < 10; i++) begin
         exp_g = (i == 8) ? 2'b10 : 2'b01;
         @(negedge clk);
         checks++;
         if (gnt !== exp_g) begin
            errors++;
            $display("FAIL forced_gnt[%0d] got=%b exp=%b", i, gnt, exp_g);
         end
         push_rsp(exp_g, exp_g[1] ? ref_mem[3] : ref_mem[5]);
         @(posedge clk); #1;
      end
      idle_ports();
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (gnt !== 2'b00) begin
            errors++;
            $display("FAIL forced_tail_gnt[%0d] got=%b exp=00", i, gnt);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_lock();
      set_port(0, 1'b1, 1'b0, 1'b1, 4'd5, 8'h00);
      @(negedge clk);
      checks++;
      if (gnt !== 2'b01) begin
         errors++;
         $display("FAIL rstlock_enter got=%b exp=01", gnt);
      end
      push_rsp(2'b01, ref_mem[5]);
      @(posedge clk); #1;
      set_port(1, 1'b1, 1'b0, 1'b0, 4'd9, 8'h00);
      @(negedge clk);
      checks++;
      if (gnt !== 2'b01) begin
         errors++;
         $display("FAIL rstlock_own got=%b exp=01", gnt);
      end
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (gnt !== 2'b00 || mem_E !== 1'b0) begin
         errors++;
         $display("FAIL rstlock_in_reset gnt=%b E=%b exp 00/0", gnt, mem_E);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_port(0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00);
      @(negedge clk);
      checks++;
      if (gnt !== 2'b10 || rvalid !== 2'b00) begin
         errors++;
         $display("FAIL rstlock_release gnt=%b rvalid=%b exp 10/00", gnt, rvalid);
      end
      push_rsp(2'b10, ref_mem[9]);
      @(posedge clk); #1;
      idle_ports();
   endtask

   task automatic test_drain();
      repeat (3) begin
         @(posedge clk); #1;
      end
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d exp=0", sbq.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         mem[i]     = 8'h00;
         ref_mem[i] = 8'h00;
      end
      rst_n = 1'b0;
      idle_ports();
      test_reset();
      test_write_read();
      test_back_to_back();
      test_lock();
      test_forced_release();
      test_reset_lock();
      test_drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
